// File: rtl/btn_event_pkg.sv
// btn_event_pkg: shared state encoding and default constants for button_event_fsm
package btn_event_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;
    localparam int LONG_CYCLES_DEF   = 25_000_000;
    localparam int REPEAT_CYCLES_DEF = 5_000_000;
    localparam int PRESS_CNT_W       = 8;
endpackage

// File: rtl/button_event_fsm_edge_detect.sv
// edge_detect: registers the debounced level and flags its rising and falling edges
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic db,
    output logic rise,
    output logic fall
);
    logic db_q;
    always_ff @(posedge clk) begin
        if (reset) db_q <= 1'b0;
        else       db_q <= db;
    end
    assign rise = db & ~db_q;
    assign fall = ~db & db_q;
endmodule

// File: rtl/button_event_fsm.sv
// button_event_fsm: press/release/long-hold/auto-repeat event pulses from a debounced button
// Auto-repeat is built only when BTN_EVENT_AUTOREPEAT_EN is defined.
module button_event_fsm
    import btn_event_pkg::*;
#(
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   db,
    output logic                   press_tick,
    output logic                   release_tick,
    output logic                   long_tick,
    output logic                   repeat_tick,
    output logic                   held,
    output logic [PRESS_CNT_W-1:0] press_count
);
    localparam int LW = $clog2(LONG_CYCLES) + 1;

    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("button_event_fsm: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    state_t        state, state_n;
    logic [LW-1:0] lcnt, lcnt_n;
    logic          rise, fall;
    logic          press_n, release_n, long_n;

    edge_detect u_edge (
        .clk  (clk),
        .reset(reset),
        .db   (db),
        .rise (rise),
        .fall (fall)
    );

`ifdef BTN_EVENT_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    logic [RW-1:0] rcnt, rcnt_n;
    logic          repeat_n;
`endif

    always_comb begin
        state_n   = IDLE;
        lcnt_n    = lcnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
`ifdef BTN_EVENT_AUTOREPEAT_EN
        rcnt_n    = rcnt;
        repeat_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                state_n = rise ? PRESSED : IDLE;
                press_n = rise;
                lcnt_n  = '0;
            end
            PRESSED: begin
                // a release landing on the long threshold wins over long_tick
                if (fall) begin
                    release_n = 1'b1;
                end else if (lcnt == LW'(LONG_CYCLES - 1)) begin
                    state_n = LONG;
                    long_n  = 1'b1;
`ifdef BTN_EVENT_AUTOREPEAT_EN
                    rcnt_n  = '0;
`endif
                end else begin
                    state_n = PRESSED;
                    lcnt_n  = lcnt + 1'b1;
                end
            end
            LONG: begin
                release_n = fall;
                state_n   = fall ? IDLE : LONG;
`ifdef BTN_EVENT_AUTOREPEAT_EN
                if (!fall) begin
                    repeat_n = (rcnt == RW'(REPEAT_CYCLES - 1));
                    rcnt_n   = repeat_n ? '0 : rcnt + 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lcnt         <= '0;
            press_tick   <= 1'b0;
            release_tick <= 1'b0;
            long_tick    <= 1'b0;
            held         <= 1'b0;
            press_count  <= '0;
        end else begin
            state        <= state_n;
            lcnt         <= lcnt_n;
            press_tick   <= press_n;
            release_tick <= release_n;
            long_tick    <= long_n;
            held         <= (state_n != IDLE);
            press_count  <= press_count + PRESS_CNT_W'(press_n);
        end
    end

`ifdef BTN_EVENT_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt        <= '0;
            repeat_tick <= 1'b0;
        end else begin
            rcnt        <= rcnt_n;
            repeat_tick <= repeat_n;
        end
    end
`else
    assign repeat_tick = 1'b0;
`endif
endmodule

// File: tb/tb_button_event_fsm.sv
// tb_button_event_fsm: table-driven check of button_event_fsm with LONG_CYCLES=8, REPEAT_CYCLES=4
module tb_button_event_fsm;
    localparam int PR = 12, RL = 11, LG = 10, RP = 9, HD = 8;

    typedef struct {
        logic        db;
        logic [12:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       db = 1'b0;
    logic       press_tick, release_tick, long_tick, repeat_tick, held;
    logic [7:0] press_count;
    int         total = 0;
    int         passed = 0;
    int         overlap = 0;
    vec_t       vec [32];

    button_event_fsm #(.LONG_CYCLES(8), .REPEAT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .db          (db),
        .press_tick  (press_tick),
        .release_tick(release_tick),
        .long_tick   (long_tick),
        .repeat_tick (repeat_tick),
        .held        (held),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (press_tick && release_tick) overlap++;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [12:0] outs();
        return {press_tick, release_tick, long_tick, repeat_tick, held, press_count};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got p/r/l/rp/h=%b cnt=%0d, want p/r/l/rp/h=%b cnt=%0d",
                      name, act[12:8], act[7:0], exp[12:8], exp[7:0]);
    endtask

    task automatic step(input logic v);
        db = v;
        @(posedge clk);
        #1;
    endtask

    // db high for edges 0..hi-1 then low; press at entry 0, release at entry hi
    task automatic fill_hold(input int hi, input int n, input logic [7:0] cnt);
        for (int k = 0; k < n; k++) begin
            vec[k].db  = (k < hi);
            vec[k].exp = {5'b0, cnt};
            vec[k].exp[HD] = (k < hi);
        end
        vec[0].exp[PR]  = 1'b1;
        vec[hi].exp[RL] = 1'b1;
    endtask

    task automatic run_table(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            step(vec[k].db);
            check($sformatf("%s t=%0d", name, k + 1), outs(), vec[k].exp);
        end
    endtask

    initial begin
        step(1'b1);
        step(1'b1);
        check("reset_state", outs(), 13'd0);
        reset = 1'b0;
        step(1'b0);
        check("idle_after_reset", outs(), 13'd0);

        fill_hold(3, 5, 8'd1);
        run_table("short", 5);

        fill_hold(20, 22, 8'd2);
        vec[8].exp[LG] = 1'b1;
`ifdef BTN_EVENT_AUTOREPEAT_EN
        vec[12].exp[RP] = 1'b1;
        vec[16].exp[RP] = 1'b1;
`endif
        run_table("long", 22);

        fill_hold(8, 10, 8'd3);
        run_table("rel_at_long", 10);

        for (int i = 0; i < 252; i++) begin
            step(1'b1);
            step(1'b0);
        end
        step(1'b0);
        check("count_255", outs(), {5'b0, 8'd255});
        step(1'b1);
        check("count_wrap", outs(), {5'b10001, 8'd0});
        step(1'b0);
        check("wrap_release", outs(), {5'b01000, 8'd0});
        step(1'b0);

        step(1'b1);
        check("hold_press", outs(), {5'b10001, 8'd1});
        for (int i = 0; i < 3; i++) step(1'b1);
        reset = 1'b1;
        step(1'b1);
        check("reset_mid_hold", outs(), 13'd0);
        step(1'b1);
        check("reset_held", outs(), 13'd0);
        reset = 1'b0;
        step(1'b1);
        check("press_after_reset", outs(), {5'b10001, 8'd1});
        step(1'b0);
        check("release_after_reset", outs(), {5'b01000, 8'd1});
        step(1'b0);
        check("idle_end", outs(), {5'b0, 8'd1});

        check("press_release_overlap", 13'(overlap), 13'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
